leaf_out_packetizer: RTL and testbench
======================================

Name: leaf_out_packetizer

Overview:
Parametrised output-side packetizer for a leaf shell. It takes NUM_OUT_PORTS user output streams (valid/ack, PAYLOAD_BITS wide), arbitrates them round-robin, and stamps each word with the destination leaf, destination port and a per-port write address. It emits one BFT packet per cycle at most. Per-port credit counters, replenished by freespace updates, gate each stream so the downstream BRAM never overflows. It sits between the user kernel outputs and the leaf's bft-facing output and generalises the fixed two-output leaf shell to N outputs with flow control.

Parameters:
NUM_OUT_PORTS, 2, number of user output streams (1..15)
PAYLOAD_BITS, 32, payload width
NUM_LEAF_BITS, 5, destination leaf field width
NUM_PORT_BITS, 4, destination port field width; also the width of the cfg/credit index
NUM_ADDR_BITS, 7, write-address field width; address wraps modulo 2^NUM_ADDR_BITS
CREDIT_MAX, 128, credit reset value and saturation ceiling
PACKET_BITS, 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS (=49), derived localparam, not overridable

Ports:
clk  in  1  single clock; all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset
din_user2pkt  in  NUM_OUT_PORTS*PAYLOAD_BITS  payloads; port p occupies bits [p*PAYLOAD_BITS +: PAYLOAD_BITS]
vld_user2pkt  in  NUM_OUT_PORTS  per-port valid
ack_pkt2user  out  NUM_OUT_PORTS  per-port accept; a transfer occurs when vld&&ack
cfg_wr  in  1  configuration write strobe
cfg_idx  in  NUM_PORT_BITS  port being configured
cfg_dest_leaf  in  NUM_LEAF_BITS  destination leaf
cfg_dest_port  in  NUM_PORT_BITS  destination port
credit_vld  in  1  freespace update strobe
credit_idx  in  NUM_PORT_BITS  port being credited
credit_amt  in  NUM_ADDR_BITS+1  credits returned
resend  in  1  suspend output
dout_pkt  out  PACKET_BITS  packet {valid, leaf, port, addr, payload}, MSB first
err_credit_ovf  out  1  sticky credit-overflow flag

Behaviour:
- Reset (async assert, sync release):
  - dout_pkt=0, ack=0, err_credit_ovf=0
  - every credit=CREDIT_MAX, every addr counter=0
  - all ports unconfigured; round-robin pointer=0
- Eligibility: port p is eligible when vld[p] && configured[p] && credit[p]!=0 && !resend.
- Arbitration: one grant per cycle, round-robin. Search starts at (last granted + 1) mod NUM_OUT_PORTS. The pointer advances only on a grant.
- ack is combinational: ack[p]=grant[p]. At most one bit is set; ack never asserts without vld.
- Latency: the packet appears on dout_pkt the cycle after the handshake, registered with valid bit = 1.
  - Field order: {1'b1, dest_leaf[p], dest_port[p], addr[p], payload}.
  - On a cycle with no grant, dout_pkt=0.
- Address: addr[p] increments by 1 per grant and wraps from 2^NUM_ADDR_BITS-1 to 0.
- Credit update per port each cycle: new = credit - grant + (credit_vld && credit_idx==p ? credit_amt : 0).
  - Simultaneous decrement and increment are both applied.
  - A result above CREDIT_MAX saturates to CREDIT_MAX and sets err_credit_ovf. The flag clears only on reset.
- Configuration:
  - cfg_wr stores dest_leaf/dest_port for cfg_idx, marks the port configured and clears its addr counter. Credit is unchanged.
  - A cfg_wr to a port granted in the same cycle takes effect from the next cycle; the current packet uses the old fields.
- Indices >= NUM_OUT_PORTS on cfg_idx or credit_idx are ignored (no state change).
- resend:
  - While high: no grants, dout_pkt forced to 0 combinationally (including a packet registered the previous cycle).
  - Credits and addresses hold, apart from credit increments.
  - Normal arbitration resumes the cycle after resend falls.
- Reset mid-operation discards the in-flight packet; dout_pkt=0 immediately.

Optional Feature:
PKT_STATS_EN:
- When defined: adds input stat_idx (NUM_PORT_BITS) and output stat_cnt (32).
  - Each port has a 32-bit wrapping count of granted packets, reset to 0.
  - stat_cnt is registered, reflecting stat_idx from the previous cycle.
  - Reading an out-of-range stat_idx returns 0.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, configure port0->(leaf 3, port 2); assert vld0 with payload 0xDEADBEEF -> ack0 the same cycle; next cycle dout_pkt={1,5'd3,4'd2,7'd0,32'hDEADBEEF}; the following word carries addr 1.
- NUM_OUT_PORTS=2, both ports configured, both vld held high for 6 cycles -> grants alternate 0,1,0,1,0,1; each port's addr reaches 3.
- Credit exhaustion: credit_amt pulses to reduce port1's available credit to 2 (via sends), vld1 held high -> exactly 2 acks then ack1=0; credit_vld idx1 amt 5 -> transfers resume the next cycle.
- Simultaneous grant and credit_vld (amt 1) on the same port at credit=CREDIT_MAX -> credit stays CREDIT_MAX, err_credit_ovf stays 0; credit_amt 2 at CREDIT_MAX -> err_credit_ovf=1, credit=CREDIT_MAX.
- Assert resend for 4 cycles during streaming -> ack=0 and dout_pkt=0 throughout; after release, the addr sequence continues without gap or repeat.
- Addr wrap: 130 packets on port0 with credits replenished -> 128th packet has addr 127, 129th has addr 0; an unconfigured port with vld high never sees ack.

Source files
------------

// File: rtl/leaf_out_packetizer.sv
// Round-robin output packetizer for a leaf shell: N user streams -> one BFT packet per cycle,
// with per-port destination config, write-address counters and credit flow control.
// Optional per-port grant counters are compiled in with `define PKT_STATS_EN.
module leaf_out_packetizer #(
  parameter int NUM_OUT_PORTS = 2,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int CREDIT_MAX    = 128,
  localparam int PACKET_BITS  = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user2pkt,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user2pkt,
  output logic [NUM_OUT_PORTS-1:0]                ack_pkt2user,
  input  logic                                    cfg_wr,
  input  logic [NUM_PORT_BITS-1:0]                cfg_idx,
  input  logic [NUM_LEAF_BITS-1:0]                cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]                cfg_dest_port,
  input  logic                                    credit_vld,
  input  logic [NUM_PORT_BITS-1:0]                credit_idx,
  input  logic [NUM_ADDR_BITS:0]                  credit_amt,
  input  logic                                    resend,
`ifdef PKT_STATS_EN
  input  logic [NUM_PORT_BITS-1:0]                stat_idx,
  output logic [31:0]                             stat_cnt,
`endif
  output logic [PACKET_BITS-1:0]                  dout_pkt,
  output logic                                    err_credit_ovf
);

  localparam int N   = NUM_OUT_PORTS;
  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = $clog2(CREDIT_MAX + 1);
  localparam int AW1 = NUM_ADDR_BITS + 1;
  // One extra bit so credit + returned amount can exceed CREDIT_MAX without wrapping.
  localparam int SW  = ((CW > AW1) ? CW : AW1) + 1;
  localparam logic [SW-1:0] CMAX_S = SW'(CREDIT_MAX);

  logic [N-1:0]             configured;
  logic [NUM_LEAF_BITS-1:0] leaf_q   [N];
  logic [NUM_PORT_BITS-1:0] port_q   [N];
  logic [NUM_ADDR_BITS-1:0] addr_q   [N];
  logic [CW-1:0]            credit_q [N];
  logic [CW-1:0]            credit_d [N];
  logic [PW-1:0]            rr_ptr;
  logic [N-1:0]             eligible;
  logic [N-1:0]             grant;
  logic [PW-1:0]            grant_idx;
  logic                     any_grant;
  logic                     ovf_hit;
  logic [PACKET_BITS-1:0]   pkt_d;
  logic [PACKET_BITS-1:0]   pkt_q;

  // NOTE: every output of a combinational block is given a default before any
  // conditional logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < N; p++) begin
      eligible[p] = vld_user2pkt[p] && configured[p] && (credit_q[p] != '0) && !resend;
    end
  end

  // Two passes give the wrap-around search: ports at/after rr_ptr first, then the rest.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (!any_grant && eligible[p] && (PW'(p) >= rr_ptr)) begin
        grant[p]  = 1'b1;
        grant_idx = PW'(p);
        any_grant = 1'b1;
      end
    end
    for (int p = 0; p < N; p++) begin
      if (!any_grant && eligible[p] && (PW'(p) < rr_ptr)) begin
        grant[p]  = 1'b1;
        grant_idx = PW'(p);
        any_grant = 1'b1;
      end
    end
  end

  assign ack_pkt2user = grant;

  always_comb begin
    pkt_d = '0;
    for (int p = 0; p < N; p++) begin
      if (grant[p]) begin
        pkt_d = {1'b1, leaf_q[p], port_q[p], addr_q[p],
                 din_user2pkt[p*PAYLOAD_BITS +: PAYLOAD_BITS]};
      end
    end
  end

  always_comb begin
    logic [SW-1:0] sum;
    sum     = '0;
    ovf_hit = 1'b0;
    for (int p = 0; p < N; p++) begin
      sum = SW'(credit_q[p]) - SW'(grant[p]) +
            ((credit_vld && (credit_idx == NUM_PORT_BITS'(p))) ? SW'(credit_amt) : '0);
      if (sum > CMAX_S) begin
        credit_d[p] = CW'(CREDIT_MAX);
        ovf_hit     = 1'b1;
      end else begin
        credit_d[p] = CW'(sum);
      end
    end
  end

  // resend masks even a packet registered on the previous cycle.
  assign dout_pkt = resend ? '0 : pkt_q;

  // NOTE: the per-port tables are small flop arrays, not RAM, so they are reset
  // along with everything else and a packet can never carry X fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q          <= '0;
      rr_ptr         <= '0;
      err_credit_ovf <= 1'b0;
      configured     <= '0;
      for (int p = 0; p < N; p++) begin
        leaf_q[p]   <= '0;
        port_q[p]   <= '0;
        addr_q[p]   <= '0;
        credit_q[p] <= CW'(CREDIT_MAX);
      end
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order.
      pkt_q <= pkt_d;
      if (any_grant) begin
        rr_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + PW'(1);
      end
      if (ovf_hit) begin
        err_credit_ovf <= 1'b1;
      end
      for (int p = 0; p < N; p++) begin
        credit_q[p] <= credit_d[p];
        if (cfg_wr && (cfg_idx == NUM_PORT_BITS'(p))) begin
          leaf_q[p]     <= cfg_dest_leaf;
          port_q[p]     <= cfg_dest_port;
          configured[p] <= 1'b1;
          addr_q[p]     <= '0;
        end else if (grant[p]) begin
          addr_q[p] <= addr_q[p] + NUM_ADDR_BITS'(1);
        end
      end
    end
  end

`ifdef PKT_STATS_EN
  logic [31:0] stat_q [N];
  logic [31:0] stat_sel;

  always_comb begin
    stat_sel = '0;
    for (int p = 0; p < N; p++) begin
      if (stat_idx == NUM_PORT_BITS'(p)) begin
        stat_sel = stat_q[p];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_cnt <= '0;
      for (int p = 0; p < N; p++) begin
        stat_q[p] <= '0;
      end
    end else begin
      stat_cnt <= stat_sel;
      for (int p = 0; p < N; p++) begin
        if (grant[p]) begin
          stat_q[p] <= stat_q[p] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Directed bench for leaf_out_packetizer (two ports, default parameters): handshake,
// round-robin, credit exhaustion/overflow, resend masking, address wrap and reset.
module tb_leaf_out_packetizer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] din;
  logic [1:0]  vld;
  logic [1:0]  ack;
  logic        cfg_wr;
  logic [3:0]  cfg_idx;
  logic [4:0]  cfg_dest_leaf;
  logic [3:0]  cfg_dest_port;
  logic        credit_vld;
  logic [3:0]  credit_idx;
  logic [7:0]  credit_amt;
  logic        resend;
  logic [48:0] dout;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;

  leaf_out_packetizer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .din_user2pkt  (din),
    .vld_user2pkt  (vld),
    .ack_pkt2user  (ack),
    .cfg_wr        (cfg_wr),
    .cfg_idx       (cfg_idx),
    .cfg_dest_leaf (cfg_dest_leaf),
    .cfg_dest_port (cfg_dest_port),
    .credit_vld    (credit_vld),
    .credit_idx    (credit_idx),
    .credit_amt    (credit_amt),
    .resend        (resend),
    .dout_pkt      (dout),
    .err_credit_ovf(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] pkt(input logic [4:0] l, input logic [3:0] pt,
                                      input logic [6:0] a, input logic [31:0] d);
    return {1'b1, l, pt, a, d};
  endfunction

  // Drive one cycle of user data, check ack combinationally, then the packet after the edge.
  task automatic step(input string tag, input logic [1:0] v, input logic [31:0] d0,
                      input logic [31:0] d1, input logic [1:0] exp_ack,
                      input logic [48:0] exp_dout);
    vld = v;
    din = {d1, d0};
    #1;
    check({tag, " ack"}, 64'(ack), 64'(exp_ack));
    @(posedge clk);
    #1;
    check({tag, " dout"}, 64'(dout), 64'(exp_dout));
  endtask

  initial begin
    bit ok;
    reset_n = 1'b0; din = '0; vld = '0; cfg_wr = 1'b0; cfg_idx = '0;
    cfg_dest_leaf = '0; cfg_dest_port = '0; credit_vld = 1'b0; credit_idx = '0;
    credit_amt = '0; resend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vld = 2'b11;
    #1;
    check("reset ack", 64'(ack), 64'd0);
    check("reset dout", 64'(dout), 64'd0);
    check("reset err", 64'(err), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Nothing configured yet: valid alone must not be acknowledged.
    step("unconfigured", 2'b11, 32'h1, 32'h2, 2'b00, '0);

    cfg_wr = 1'b1; cfg_idx = 4'd0; cfg_dest_leaf = 5'd3; cfg_dest_port = 4'd2;
    step("cfg port0", 2'b00, '0, '0, 2'b00, '0);
    cfg_wr = 1'b0;

    // Port1 still unconfigured with valid high: only port0 is served.
    step("first word", 2'b11, 32'hDEADBEEF, 32'h1, 2'b01, pkt(5'd3, 4'd2, 7'd0, 32'hDEADBEEF));
    step("second word", 2'b01, 32'h12345678, '0, 2'b01, pkt(5'd3, 4'd2, 7'd1, 32'h12345678));
    step("idle", 2'b00, '0, '0, 2'b00, '0);

    cfg_wr = 1'b1; cfg_idx = 4'd1; cfg_dest_leaf = 5'd7; cfg_dest_port = 4'd9;
    step("cfg port1", 2'b00, '0, '0, 2'b00, '0);
    cfg_idx = 4'd0; cfg_dest_leaf = 5'd3; cfg_dest_port = 4'd2;
    step("recfg port0", 2'b00, '0, '0, 2'b00, '0);
    cfg_wr = 1'b0;

    // Pointer sits at 1 after the last port0 grant, so port1 goes first.
    step("rr0", 2'b11, 32'hA0, 32'hB0, 2'b10, pkt(5'd7, 4'd9, 7'd0, 32'hB0));
    step("rr1", 2'b11, 32'hA1, 32'hB1, 2'b01, pkt(5'd3, 4'd2, 7'd0, 32'hA1));
    step("rr2", 2'b11, 32'hA2, 32'hB2, 2'b10, pkt(5'd7, 4'd9, 7'd1, 32'hB2));
    step("rr3", 2'b11, 32'hA3, 32'hB3, 2'b01, pkt(5'd3, 4'd2, 7'd1, 32'hA3));
    step("rr4", 2'b11, 32'hA4, 32'hB4, 2'b10, pkt(5'd7, 4'd9, 7'd2, 32'hB4));
    step("rr5", 2'b11, 32'hA5, 32'hB5, 2'b01, pkt(5'd3, 4'd2, 7'd2, 32'hA5));

    // Out-of-range cfg index must not touch port0 (fields and addr 3 preserved).
    cfg_wr = 1'b1; cfg_idx = 4'd2; cfg_dest_leaf = 5'd31; cfg_dest_port = 4'd15;
    step("cfg oor", 2'b00, '0, '0, 2'b00, '0);
    cfg_wr = 1'b0;
    step("after cfg oor", 2'b01, 32'hC1, '0, 2'b01, pkt(5'd3, 4'd2, 7'd3, 32'hC1));

    // Port1 holds 125 credits at addr 3; drain 123 to leave exactly 2.
    ok = 1'b1;
    for (int i = 0; i < 123; i++) begin
      vld = 2'b10;
      din = {32'(i), 32'h0};
      #1;
      if (ack !== 2'b10) ok = 1'b0;
      @(posedge clk);
      #1;
    end
    check("drain acks", 64'(ok), 64'd1);
    step("credit 2", 2'b10, '0, 32'hE0, 2'b10, pkt(5'd7, 4'd9, 7'd126, 32'hE0));
    step("credit 1", 2'b10, '0, 32'hE1, 2'b10, pkt(5'd7, 4'd9, 7'd127, 32'hE1));
    step("credit 0a", 2'b10, '0, 32'hE2, 2'b00, '0);
    step("credit 0b", 2'b10, '0, 32'hE3, 2'b00, '0);
    credit_vld = 1'b1; credit_idx = 4'd1; credit_amt = 8'd5;
    step("replenish", 2'b10, '0, 32'hE4, 2'b00, '0);
    credit_vld = 1'b0;
    step("resumed", 2'b10, '0, 32'hE5, 2'b10, pkt(5'd7, 4'd9, 7'd0, 32'hE5));

    // Port0 at 122 credits: an out-of-range index carrying 100 must be ignored.
    credit_vld = 1'b1; credit_idx = 4'd2; credit_amt = 8'd100;
    step("credit oor", 2'b00, '0, '0, 2'b00, '0);
    check("credit oor err", 64'(err), 64'd0);
    credit_idx = 4'd0; credit_amt = 8'd6;
    step("fill to max", 2'b00, '0, '0, 2'b00, '0);
    check("exact max err", 64'(err), 64'd0);
    credit_amt = 8'd1;
    step("grant+credit", 2'b01, 32'hF0, '0, 2'b01, pkt(5'd3, 4'd2, 7'd4, 32'hF0));
    check("grant+credit err", 64'(err), 64'd0);
    credit_amt = 8'd2;
    step("overflow", 2'b00, '0, '0, 2'b00, '0);
    credit_vld = 1'b0;
    check("overflow err", 64'(err), 64'd1);
    step("sticky", 2'b00, '0, '0, 2'b00, '0);
    check("sticky err", 64'(err), 64'd1);

    // resend masks the registered packet at once and stalls the stream.
    step("pre resend", 2'b01, 32'h60, '0, 2'b01, pkt(5'd3, 4'd2, 7'd5, 32'h60));
    resend = 1'b1;
    #1;
    check("resend masks dout", 64'(dout), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      step($sformatf("resend%0d", i), 2'b01, 32'(32'h60 + i), '0, 2'b00, '0);
    end
    resend = 1'b0;
    step("post resend", 2'b01, 32'h66, '0, 2'b01, pkt(5'd3, 4'd2, 7'd6, 32'h66));
    step("post resend2", 2'b01, 32'h67, '0, 2'b01, pkt(5'd3, 4'd2, 7'd7, 32'h67));

    // Reconfigure during a grant: this packet keeps old fields, the next starts at addr 0.
    cfg_wr = 1'b1; cfg_idx = 4'd0; cfg_dest_leaf = 5'd9; cfg_dest_port = 4'd4;
    step("cfg during grant", 2'b01, 32'h70, '0, 2'b01, pkt(5'd3, 4'd2, 7'd8, 32'h70));
    cfg_wr = 1'b0;

    credit_vld = 1'b1; credit_idx = 4'd0; credit_amt = 8'd1;
    for (int i = 0; i < 130; i++) begin
      step($sformatf("wrap%0d", i), 2'b01, 32'(i), '0, 2'b01,
           pkt(5'd9, 4'd4, 7'(i), 32'(i)));
    end
    credit_vld = 1'b0;

    // Async reset with a packet on the output clears it immediately.
    vld = 2'b01;
    reset_n = 1'b0;
    #1;
    check("mid reset dout", 64'(dout), 64'd0);
    check("mid reset ack", 64'(ack), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
